const_time_mult: RTL
====================

CONST_TIME_MULT -- requirements
Module: const_time_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a multiply.
REQ-005 SHALL have port multiplier  input  WIDTH  operand A, sampled on the accepting edge.
REQ-006 SHALL have port multiplicand  input  WIDTH  operand B, sampled on the accepting edge.
REQ-007 SHALL have port is_signed  input  1  two's-complement mode select; present only when CT_MULT_SIGNED_EN is defined.
REQ-008 SHALL have port ready  output  1  high when start will be accepted.
REQ-009 SHALL have port busy  output  1  high while an operation iterates.
REQ-010 SHALL have port product  output  2*WIDTH  result register.
REQ-011 SHALL have port productDone  output  1  single-cycle result-valid pulse.

Function
REQ-012 SHALL implement FSM states IDLE, ITER and DONE.
REQ-013 SHALL accept start only when ready=1; ready=1 in IDLE and DONE, 0 in ITER.
REQ-014 Accepting edge SHALL capture both operands (and is_signed), clear the running sum and counter, and enter ITER.
REQ-015 ITER SHALL last exactly WIDTH cycles, one multiplier bit per cycle, LSB first; counter runs 0..WIDTH-1.
REQ-016 Each ITER cycle SHALL always evaluate the adder and select the result with a mux on the current multiplier bit; no state or cycle-count branch may depend on operand values.
REQ-017 Running sum SHALL be 2*WIDTH+1 bits wide to hold the carry; product takes the low 2*WIDTH bits.
REQ-018 On leaving ITER, FSM SHALL enter DONE, update product, and assert productDone for exactly that one DONE cycle, WIDTH cycles after the accepting edge.
REQ-019 DONE SHALL return to IDLE after one cycle unless start=1, in which case a new operation is accepted back-to-back.
REQ-020 product SHALL hold its value until the next DONE entry; start during ITER SHALL be ignored, with no queuing.
REQ-021 busy SHALL equal (state==ITER).
REQ-022 Latency SHALL be identical for all operand values and modes.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, product=0, productDone=0, busy=0, ready=1, and clear the counter and internal registers.
REQ-024 Reset during ITER SHALL abort the operation with no productDone pulse; the first start after reset deassertion is accepted normally.

Configuration
REQ-025 With CT_MULT_SIGNED_EN defined, is_signed=1 SHALL produce the signed 2*WIDTH product: the final ITER cycle subtracts instead of adds, and right shifts are arithmetic; latency is unchanged.
REQ-026 Without CT_MULT_SIGNED_EN, the is_signed port and signed logic SHALL be absent and all operands are treated as unsigned.

Structure
REQ-027 Shared package const_time_mult_pkg SHALL hold the FSM state typedef and the counter-width function/constant.
REQ-028 The datapath (operand registers, running sum, adder/subtractor, shifter) SHALL be sub-module const_time_mult_dpath, and control SHALL stay in const_time_mult.

Verification
REQ-029 WIDTH=8, unsigned 0xFF*0xFF -> product 0xFE01, productDone exactly 8 cycles after the accepting edge.
REQ-030 0x00*0x00, 0x01*0x80 and 0xFF*0xFF -> identical latency to the cycle; products 0x0000, 0x0080, 0xFE01.
REQ-031 CT_MULT_SIGNED_EN, is_signed=1: 0xFD*0x05 -> 0xFFF1; 0x80*0x80 -> 0x4000; both at 8-cycle latency.
REQ-032 start pulsed during ITER cycle 4 with other operands -> ignored; original product delivered and ready low throughout ITER.
REQ-033 rst asserted during ITER cycle 3 -> product=0 and ready=1 immediately, with no productDone; next start (0x03*0x04) -> 0x000C.
REQ-034 start held high in DONE with new operands 0x10*0x10 -> accepted with no IDLE cycle; 0x0100 delivered 8 cycles later.

Source files
------------

// File: rtl/const_time_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : const_time_mult_pkg
//  Purpose  : Shared definitions for the constant-time multiplier: the
//             control FSM state encoding and the iteration-counter width.
//  Contents : state_t    - FSM state type (IDLE, ITER, DONE)
//             cnt_width  - counter width needed to count 0..w-1
//  Revision : 1.0 - initial release
// ============================================================================
package const_time_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed for a counter that runs 0..w-1 (never less than one bit).
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage : const_time_mult_pkg
`default_nettype wire

// File: rtl/const_time_mult_dpath.sv
`default_nettype none
// ============================================================================
//  Module   : const_time_mult_dpath
//  Purpose  : Shift-add datapath for the constant-time multiplier. Holds the
//             operand registers and the 2*WIDTH+1 bit running sum. Every step
//             evaluates the adder; the current multiplier bit only steers a
//             mux, so timing and activity pattern are operand independent.
//  Ports    : clk, rst        - clock, asynchronous active-high reset
//             load            - capture operands, clear running sum
//             step            - perform one iteration (one multiplier bit)
//             last            - current step handles the multiplier MSB
//             a_in, b_in      - multiplier / multiplicand
//             is_signed       - two's-complement mode (CT_MULT_SIGNED_EN only)
//             sum_next        - low 2*WIDTH bits of the next running sum
//  Config   : CT_MULT_SIGNED_EN enables the signed mode.
//  Revision : 1.0 - initial release
// ============================================================================
module const_time_mult_dpath #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               last,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
`ifdef CT_MULT_SIGNED_EN
  input  logic               is_signed,
`endif
  output logic [2*WIDTH-1:0] sum_next
);

  logic [WIDTH-1:0]   a_sh;     // multiplier, shifted right each step
  logic [WIDTH-1:0]   b_reg;    // multiplicand
  logic [2*WIDTH:0]   acc;      // running sum, extra top bit holds the carry

  logic [WIDTH:0]     b_ext;
  logic               sub;
  logic               fill;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     add_res;
  logic [WIDTH:0]     hi_sel;
  logic [2*WIDTH:0]   acc_nxt;

`ifdef CT_MULT_SIGNED_EN
  logic               sgn_mode;

  // The multiplier MSB carries weight -2^(WIDTH-1) in signed mode, so the
  // final step subtracts; the upper sum is a signed WIDTH+1 bit value and
  // shifts arithmetically.
  always_comb begin
    b_ext = {sgn_mode & b_reg[WIDTH-1], b_reg};
    sub   = sgn_mode & last;
  end
`else
  always_comb begin
    b_ext = {1'b0, b_reg};
    sub   = 1'b0;
  end
`endif

  // Adder/subtractor is always exercised; subtraction is add of the
  // one's complement plus one.
  always_comb begin
    addend  = b_ext ^ {(WIDTH+1){sub}};
    add_res = acc[2*WIDTH:WIDTH] + addend + {{WIDTH{1'b0}}, sub};
    hi_sel  = a_sh[0] ? add_res : acc[2*WIDTH:WIDTH];
`ifdef CT_MULT_SIGNED_EN
    fill    = sgn_mode & hi_sel[WIDTH];
`else
    fill    = 1'b0;
`endif
    acc_nxt  = {fill, hi_sel, acc[WIDTH-1:1]};
    sum_next = acc_nxt[2*WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_reg    <= '0;
      acc      <= '0;
`ifdef CT_MULT_SIGNED_EN
      sgn_mode <= 1'b0;
`endif
    end else if (load) begin
      a_sh     <= a_in;
      b_reg    <= b_in;
      acc      <= '0;
`ifdef CT_MULT_SIGNED_EN
      sgn_mode <= is_signed;
`endif
    end else if (step) begin
      acc      <= acc_nxt;
      a_sh     <= a_sh >> 1;
    end
  end

endmodule : const_time_mult_dpath
`default_nettype wire

// File: rtl/const_time_mult.sv
`default_nettype none
// ============================================================================
//  Module   : const_time_mult
//  Purpose  : Constant-time sequential multiplier. An accepted start runs
//             exactly WIDTH iteration cycles (one multiplier bit each, LSB
//             first) regardless of operand values, then presents the
//             2*WIDTH bit product with a one-cycle productDone pulse.
//  Ports    : clk          - clock, rising edge
//             rst          - asynchronous active-high reset
//             start        - begin a multiply (accepted when ready=1)
//             multiplier   - operand A
//             multiplicand - operand B
//             is_signed    - two's-complement mode (CT_MULT_SIGNED_EN only)
//             ready        - start will be accepted
//             busy         - iterating
//             product      - result register, held until the next result
//             productDone  - single-cycle result-valid pulse
//  Config   : define CT_MULT_SIGNED_EN to add the signed mode.
//  Revision : 1.0 - initial release
// ============================================================================
module const_time_mult
  import const_time_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
`ifdef CT_MULT_SIGNED_EN
  input  logic               is_signed,
`endif
  output logic               ready,
  output logic               busy,
  output logic [2*WIDTH-1:0] product,
  output logic               productDone
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH-1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 accept;
  logic                 last;
  logic [2*WIDTH-1:0]   sum_next;

  // ready is registered and is high exactly in IDLE and DONE.
  assign accept = ready & start;
  assign last   = (cnt == CNT_LAST);

  const_time_mult_dpath #(
    .WIDTH (WIDTH)
  ) u_dpath (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (busy),
    .last      (last),
    .a_in      (multiplier),
    .b_in      (multiplicand),
`ifdef CT_MULT_SIGNED_EN
    .is_signed (is_signed),
`endif
    .sum_next  (sum_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ready       <= 1'b1;
      busy        <= 1'b0;
      product     <= '0;
      productDone <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          productDone <= 1'b0;
          if (start) begin
            state <= ITER;
            cnt   <= '0;
            ready <= 1'b0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        ITER: begin
          // Cycle count depends only on the counter, never on operands.
          if (last) begin
            state       <= DONE;
            cnt         <= '0;
            product     <= sum_next;
            productDone <= 1'b1;
            ready       <= 1'b1;
            busy        <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          ready       <= 1'b1;
          busy        <= 1'b0;
          productDone <= 1'b0;
        end
      endcase
    end
  end

endmodule : const_time_mult
`default_nettype wire
